// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR tap reader.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } fir_state_t;

  // Full-precision accumulator width: product width plus growth for DEPTH terms.
  function automatic int acc_width(input int width, input int coef_width, input int depth);
    return width + coef_width + $clog2(depth);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate for one tap per cycle; clr restarts the sum.
module fir_mac
  import fir_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = WIDTH + COEF_WIDTH + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [WIDTH-1:0]      tap_data,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int PW = WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] r_acc;

  function automatic logic signed [ACC_WIDTH-1:0] sext_prod(input logic signed [PW-1:0] p);
    return {{(ACC_WIDTH - PW){p[PW-1]}}, p};
  endfunction

  assign w_prod     = tap_data * coef_data;
  assign w_prod_ext = sext_prod(w_prod);

  // Accumulate stage: the sum stays put whenever en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  assign acc = r_acc;

endmodule

// File: rtl/fir_tap_reader.sv
// Read-side controller for a shift-register sample memory: accepts a sample,
// sweeps all taps through a MAC and offers the sum on a valid/ready port.
module fir_tap_reader
  import fir_pkg::*;
#(
  parameter  int DEPTH      = 8,
  parameter  int WIDTH      = 16,
  parameter  int COEF_WIDTH = 16,
  localparam int ACC_WIDTH  = acc_width(WIDTH, COEF_WIDTH, DEPTH),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         mem_write_en,
  output logic [AW-1:0]                tap_addr,
  input  logic signed [WIDTH-1:0]      tap_data,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_valid,
  input  logic                         out_ready
);

  fir_state_t                  r_state;
  logic [AW-1:0]               r_tap_addr;
  logic                        r_out_valid;
  logic                        w_accept;
  logic                        w_last;
  logic                        w_mac_en;
  logic signed [ACC_WIDTH-1:0] w_acc;

  // A finished result can be handed off and a new sample taken in the same cycle.
  assign in_ready     = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign mem_write_en = w_accept;
  assign w_last       = (r_tap_addr == AW'(DEPTH - 1));
  assign w_mac_en     = (r_state == ACCUM);

  fir_mac #(
    .WIDTH      (WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr       (w_accept),
    .en        (w_mac_en),
    .tap_data  (tap_data),
    .coef_data (coef_data),
    .acc       (w_acc)
  );

  // Control stage: the wrap of the tap counter is explicit for any DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tap_addr  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= ACCUM;
            r_tap_addr <= '0;
          end
        end
        ACCUM: begin
          if (w_last) begin
            r_tap_addr  <= '0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_tap_addr <= r_tap_addr + AW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_tap_addr  <= '0;
            r_state     <= in_valid ? ACCUM : IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_tap_addr  <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // The accumulator already holds the finished sum once ACCUM ends and is
  // frozen until the next accept, so it doubles as the output register.
  assign out_data  = w_acc;
  assign out_valid = r_out_valid;
  assign tap_addr  = r_tap_addr;

endmodule

// File: tb/tb_fir_tap_reader.sv
// Scoreboard bench for fir_tap_reader with a behavioural sample memory and coefficient ROM.
module tb_fir_tap_reader;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
  localparam int CW    = 8;
  localparam int AW    = $clog2(DEPTH);
  localparam int ACC_W = WIDTH + CW + $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic in_ready, mem_write_en, out_valid;
  logic [AW-1:0] tap_addr;
  logic signed [WIDTH-1:0] tap_data;
  logic signed [CW-1:0] coef_data;
  logic signed [ACC_W-1:0] out_data;
  logic signed [WIDTH-1:0] in_data = '0;

  logic signed [WIDTH-1:0] mem [DEPTH];
  int coef [DEPTH];
  int hist [DEPTH];

  typedef struct {
    int data;
    int edge_n;
  } exp_t;
  exp_t sbq [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wcount = 0;
  int last_edge = 0;
  bit rand_rdy = 1'b0;
  bit prev_vld = 1'b0;

  always #5 clk = ~clk;

  fir_tap_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .COEF_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_write_en (mem_write_en),
    .tap_addr     (tap_addr),
    .tap_data     (tap_data),
    .coef_data    (coef_data),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  // Shift-register sample memory: newest sample lands at address 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_write_en) begin
      for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
      mem[0] <= in_data;
    end
  end

  assign tap_data  = mem[tap_addr];
  assign coef_data = CW'(coef[tap_addr]);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference FIR: history of accepted samples, newest first, dotted with coefficients.
  function automatic int model_push(input int s);
    int acc;
    acc = 0;
    for (int k = DEPTH - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int k = 0; k < DEPTH; k++) acc += coef[k] * hist[k];
    return acc;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_vld = 1'b0;
    end else begin
      if (out_valid && !prev_vld) begin
        if (sbq.size() == 0) check("unexpected_valid", 1, 0);
        else check("latency_edge", cyc, sbq[0].edge_n + DEPTH);
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("spurious_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_data", longint'(out_data), longint'(e.data));
        end
      end
      if (mem_write_en) wcount++;
      prev_vld = out_valid;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sbq.delete();
    for (int k = 0; k < DEPTH; k++) hist[k] = 0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_tap_addr", tap_addr, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_write_en", mem_write_en, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge, in_valid left high.
  task automatic send(input int s);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = WIDTH'(s);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (mem_write_en) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      exp_t e;
      e.data = model_push(s);
      e.edge_n = cyc + 1;
      last_edge = cyc + 1;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (sbq.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_done", ok, 1);
    @(posedge clk); #1;
  endtask

  function automatic int rnd_s8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int held, e0, prev_edge, w0, ok;
    coef = '{1, 2, 3, 4};
    #1;
    do_reset();

    // Basic stream 1..5 -> 1, 4, 10, 20, 30
    for (int s = 1; s <= 5; s++) send(s);
    drain();

    // Sign handling across the full accumulator width
    do_reset();
    coef[0] = -128;
    send(-128);
    drain();
    coef[0] = 127;
    send(-128);
    drain();
    coef[0] = 1;

    // Downstream stall in DONE with a sample waiting
    do_reset();
    out_ready = 1'b0;
    send(5);
    in_data = WIDTH'(9);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    check("stall_valid_seen", ok, 1);
    held = int'(out_data);
    for (int i = 0; i < 10; i++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_mem_write_en", mem_write_en, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data_held", out_data, held);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    e0 = cyc;
    send(9);
    check("stall_same_cycle_accept", last_edge, e0 + 1);
    check("stall_accum_out_valid", out_valid, 0);
    check("stall_accum_in_ready", in_ready, 0);
    drain();

    // Reset in the middle of accumulation
    do_reset();
    send(3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_tap_addr", tap_addr, 2);
    do_reset();
    check("post_rst_out_data", out_data, 0);
    send(7);
    drain();

    // Back-to-back random samples
    do_reset();
    w0 = wcount;
    prev_edge = 0;
    for (int i = 0; i < 6; i++) begin
      send(rnd_s8());
      if (i > 0) check("b2b_spacing", last_edge - prev_edge, DEPTH + 1);
      prev_edge = last_edge;
    end
    drain();
    check("b2b_write_pulses", wcount - w0, 6);

    // Random coefficients, samples, gaps and downstream backpressure
    do_reset();
    for (int k = 0; k < DEPTH; k++) coef[k] = rnd_s8();
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(rnd_s8());
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
